// File: rtl/async_fill_ctrl_pkg.sv
// async_fill_ctrl_pkg: state encoding and shared constants for the fill controller
package async_fill_ctrl_pkg;
  localparam int ST_IDLE = 0;
  localparam int ST_SETUP = 1;
  localparam int ST_ARMED = 2;
  localparam int ST_DRAIN = 3;
  localparam int ST_DONE_WAIT = 4;
  localparam int ST_HOLDOFF = 5;
  localparam logic [5:0] S_IDLE = 6'b000001;
  localparam logic [5:0] S_SETUP = 6'b000010;
  localparam logic [5:0] S_ARMED = 6'b000100;
  localparam logic [5:0] S_DRAIN = 6'b001000;
  localparam logic [5:0] S_DONE_WAIT = 6'b010000;
  localparam logic [5:0] S_HOLDOFF = 6'b100000;
  localparam logic [1:0] FILL_TYPE_NONE = 2'b00;
  localparam int TRIG_CNT_W = 16;
endpackage

// File: rtl/async_fill_ctrl_sync_rise_det.sv
// sync_rise_det: 2-flop synchronizer followed by a rising-edge pulse
module sync_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  (* ASYNC_REG = "TRUE" *) logic [1:0] sync;
  logic prev;
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], d};
      prev <= sync[1];
    end
  assign rise = sync[1] & ~prev;
endmodule

// File: rtl/async_fill_ctrl.sv
// async_fill_ctrl: fill window / trigger initiator that collects channel done pulses
module async_fill_ctrl
  import async_fill_ctrl_pkg::*;
#(
  parameter int N_CHAN = 5,
  parameter int SETUP_CYC = 16,
  parameter int TRIG_WIDTH = 8,
  parameter int MIN_IDLE = 64
) (
  input  logic                  adc_clk,
  input  logic                  reset_clk_adc,
  input  logic                  fill_req,
  input  logic [1:0]            fill_type_req,
  input  logic                  trig_req,
  input  logic                  fill_end_req,
  input  logic [N_CHAN-1:0]     chan_mask,
  input  logic [23:0]           timeout_cyc,
  input  logic [N_CHAN-1:0]     ext_done_in,
  output logic                  ext_enable0,
  output logic                  ext_enable1,
  output logic                  ext_trig,
  output logic                  busy,
  output logic                  trig_drop,
  output logic [TRIG_CNT_W-1:0] trig_count,
  output logic [N_CHAN-1:0]     done_seen,
  output logic                  fill_done,
  output logic                  timeout_err
);
  localparam int GW = $clog2(2 * TRIG_WIDTH);
  logic [5:0] state, nxt;
  logic [23:0] cnt;
  logic [GW-1:0] gen_cnt;
  logic [1:0] ftype;
  logic [N_CHAN-1:0] mask, rise;
  logic pending_end, gen_idle, start, trig_ok, complete, tmo, capture;
  for (genvar i = 0; i < N_CHAN; i++) begin : g_sync
    sync_rise_det u_sync (.clk(adc_clk), .rst(reset_clk_adc), .d(ext_done_in[i]), .rise(rise[i]));
  end
  assign gen_idle = gen_cnt == '0;
  assign start = state[ST_IDLE] & fill_req & (fill_type_req != FILL_TYPE_NONE);
  assign trig_ok = state[ST_ARMED] & trig_req & gen_idle;
  assign complete = &(done_seen | ~mask);
  assign tmo = (timeout_cyc != 24'd0) && (cnt == timeout_cyc - 24'd1);
  assign capture = |(state & (S_SETUP | S_ARMED | S_DRAIN | S_DONE_WAIT));
  always_comb
    nxt = start ? S_SETUP
        : (state[ST_SETUP] && cnt == 24'(SETUP_CYC - 1)) ? S_ARMED
        : (state[ST_ARMED] && (fill_end_req || pending_end)) ? S_DRAIN
        : (state[ST_DRAIN] && gen_idle) ? S_DONE_WAIT
        : (state[ST_DONE_WAIT] && (complete || tmo)) ? S_HOLDOFF
        : (state[ST_HOLDOFF] && cnt == 24'(MIN_IDLE - 1)) ? S_IDLE
        : state;
  // The generator counts pulse plus gap; ext_trig is high for its upper TRIG_WIDTH values.
  always_ff @(posedge adc_clk)
    if (reset_clk_adc) begin
      state <= S_IDLE;
      cnt <= '0;
      gen_cnt <= '0;
      ftype <= '0;
      mask <= '0;
      pending_end <= 1'b0;
      {ext_enable1, ext_enable0} <= '0;
      ext_trig <= 1'b0;
      busy <= 1'b0;
      trig_drop <= 1'b0;
      trig_count <= '0;
      done_seen <= '0;
      fill_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? 24'd0 : cnt + 24'd1;
      gen_cnt <= trig_ok ? GW'(2 * TRIG_WIDTH - 1) : gen_idle ? gen_cnt : gen_cnt - GW'(1);
      ftype <= start ? fill_type_req : ftype;
      mask <= start ? chan_mask : mask;
      pending_end <= state[ST_SETUP] & (pending_end | fill_end_req);
      {ext_enable1, ext_enable0} <= start ? fill_type_req
                                  : |(nxt & (S_SETUP | S_ARMED | S_DRAIN)) ? ftype : 2'b00;
      ext_trig <= trig_ok | (gen_cnt > GW'(TRIG_WIDTH));
      busy <= ~nxt[ST_IDLE];
      trig_drop <= trig_req & (state[ST_SETUP] | state[ST_DRAIN] | (state[ST_ARMED] & ~gen_idle));
      trig_count <= start ? '0 : (trig_ok && ~&trig_count) ? trig_count + 1'b1 : trig_count;
      done_seen <= start ? '0 : capture ? done_seen | rise : done_seen;
      fill_done <= state[ST_DONE_WAIT] & complete;
      timeout_err <= state[ST_DONE_WAIT] & ~complete & tmo;
    end
endmodule

// File: tb/tb_async_fill_ctrl.sv
// tb_async_fill_ctrl: directed vector table plus hand-timed fill sequences
module tb_async_fill_ctrl;
  logic clk = 1'b0, rst = 1'b0, fill_req = 1'b0, trig_req = 1'b0, fill_end_req = 1'b0;
  logic [1:0] fill_type_req = 2'b00;
  logic [4:0] chan_mask = 5'b00011, ext_done_in = 5'b0, done_seen;
  logic [23:0] timeout_cyc = 24'd0;
  logic ext_enable0, ext_enable1, ext_trig, busy, trig_drop, fill_done, timeout_err;
  logic [15:0] trig_count;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    int pre;
    logic rst, freq;
    logic [1:0] ftype;
    logic treq, ereq;
    logic [1:0] en;
    logic trig, busy, drop;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[13];
  async_fill_ctrl dut (
    .adc_clk(clk), .reset_clk_adc(rst), .fill_req(fill_req), .fill_type_req(fill_type_req),
    .trig_req(trig_req), .fill_end_req(fill_end_req), .chan_mask(chan_mask),
    .timeout_cyc(timeout_cyc), .ext_done_in(ext_done_in), .ext_enable0(ext_enable0),
    .ext_enable1(ext_enable1), .ext_trig(ext_trig), .busy(busy), .trig_drop(trig_drop),
    .trig_count(trig_count), .done_seen(done_seen), .fill_done(fill_done),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse_fill(input logic [1:0] t);
    fill_req = 1'b1;
    fill_type_req = t;
    step();
    fill_req = 1'b0;
    fill_type_req = 2'b00;
  endtask
  initial begin
    logic bad_early;
    int extra;
    bit found;
    tbl[0]  = '{0,  1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{0,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{0,  1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[3]  = '{0,  1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[4]  = '{13, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[5]  = '{0,  1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[6]  = '{0,  1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 16'd1};
    tbl[7]  = '{3,  1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 16'd1};
    tbl[8]  = '{3,  1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 16'd1};
    tbl[9]  = '{3,  1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 16'd1};
    tbl[10] = '{3,  1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 16'd2};
    tbl[11] = '{6,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 16'd2};
    tbl[12] = '{0,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 16'd2};
    for (int i = 0; i < 13; i++) begin
      repeat (tbl[i].pre) step();
      {rst, fill_req, fill_type_req, trig_req, fill_end_req} =
        {tbl[i].rst, tbl[i].freq, tbl[i].ftype, tbl[i].treq, tbl[i].ereq};
      step();
      {rst, fill_req, fill_type_req, trig_req, fill_end_req} = '0;
      chk($sformatf("vec%0d_en", i), {ext_enable1, ext_enable0}, tbl[i].en);
      chk($sformatf("vec%0d_trig", i), ext_trig, tbl[i].trig);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_drop", i), trig_drop, tbl[i].drop);
      chk($sformatf("vec%0d_count", i), trig_count, tbl[i].cnt);
    end
    // same-cycle trigger and fill end, then drain with ch0 done arriving
    repeat (7) step();
    trig_req = 1'b1;
    fill_end_req = 1'b1;
    step();
    trig_req = 1'b0;
    fill_end_req = 1'b0;
    chk("drain_trig_start", ext_trig, 1);
    chk("drain_count", trig_count, 3);
    for (int j = 1; j <= 16; j++) begin
      ext_done_in[0] = (j == 2 || j == 3);
      trig_req = (j == 10);
      step();
      trig_req = 1'b0;
      chk($sformatf("drain_trig_%0d", j), ext_trig, j < 8);
      chk($sformatf("drain_en_%0d", j), {ext_enable1, ext_enable0}, (j < 16) ? 2'b10 : 2'b00);
      if (j == 10) chk("drain_drop", trig_drop, 1);
    end
    ext_done_in = '0;
    chk("dw_busy", busy, 1);
    repeat (5) step();
    chk("dw_no_done_yet", fill_done, 0);
    chk("dw_seen_ch0", done_seen, 5'b00001);
    ext_done_in[1] = 1'b1;
    step();
    step();
    ext_done_in = '0;
    found = 0;
    for (int j = 0; j < 20 && !found; j++) begin
      step();
      found = fill_done;
    end
    chk("fill_done_seen", found, 1);
    chk("done_seen_final", done_seen, 5'b00011);
    chk("no_timeout", timeout_err, 0);
    extra = 0;
    for (int j = 0; j < 63; j++) begin
      step();
      extra += int'(fill_done);
    end
    chk("single_fill_done", extra, 0);
    chk("holdoff_busy_63", busy, 1);
    step();
    chk("holdoff_busy_64", busy, 0);
    // timeout fill with early done and a fill end latched during setup
    timeout_cyc = 24'd100;
    pulse_fill(2'b01);
    chk("t_en", {ext_enable1, ext_enable0}, 2'b01);
    chk("t_count_clr", trig_count, 0);
    chk("t_seen_clr", done_seen, 0);
    fill_end_req = 1'b1;
    ext_done_in[0] = 1'b1;
    step();
    fill_end_req = 1'b0;
    step();
    ext_done_in = '0;
    repeat (15) step();
    chk("t_en_drain", {ext_enable1, ext_enable0}, 2'b01);
    step();
    chk("t_en_off", {ext_enable1, ext_enable0}, 2'b00);
    bad_early = 1'b0;
    for (int j = 0; j < 99; j++) begin
      step();
      bad_early |= timeout_err | fill_done;
    end
    chk("t_no_early", bad_early, 0);
    step();
    chk("t_timeout", timeout_err, 1);
    chk("t_no_fill_done", fill_done, 0);
    chk("t_seen_kept", done_seen, 5'b00001);
    pulse_fill(2'b11);
    chk("t_hold_rej_en", {ext_enable1, ext_enable0}, 2'b00);
    chk("t_hold_busy", busy, 1);
    repeat (62) step();
    pulse_fill(2'b11);
    chk("t_hold_end_rej", {ext_enable1, ext_enable0}, 2'b00);
    chk("t_hold_end_idle", busy, 0);
    pulse_fill(2'b11);
    chk("t_accept_en", {ext_enable1, ext_enable0}, 2'b11);
    chk("t_accept_busy", busy, 1);
    // reset while the trigger is high
    repeat (16) step();
    trig_req = 1'b1;
    step();
    trig_req = 1'b0;
    chk("r_trig_hi", ext_trig, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_en", {ext_enable1, ext_enable0}, 2'b00);
    chk("r_trig", ext_trig, 0);
    chk("r_busy", busy, 0);
    chk("r_count", trig_count, 0);
    chk("r_flags", {trig_drop, fill_done, timeout_err, done_seen}, 0);
    pulse_fill(2'b00);
    chk("r_type00_busy", busy, 0);
    chk("r_type00_en", {ext_enable1, ext_enable0}, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
